reg_scan_reader: RTL and testbench
==================================

REG_SCAN_READER -- requirements
Module: reg_scan_reader

Interface
REQ-001 SHALL have parameter FIRST_REG, default 0, first register index scanned.
REQ-002 SHALL have parameter LAST_REG, default 31, last register index scanned (FIRST_REG <= LAST_REG <= 31).
REQ-003 SHALL have parameter AUTO_REPEAT, default 0, 1 = restart at FIRST_REG after LAST_REG instead of stopping.
REQ-004 SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port Reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  pulse or level, begins a scan from IDLE.
REQ-007 SHALL have port abort  input  1  terminates an active scan.
REQ-008 SHALL have port step_tick  input  1  one-cycle dwell tick (e.g. display refresh divider).
REQ-009 SHALL have port rd_addr  output  5  read address to register-file read port.
REQ-010 SHALL have port rd_data  input  32  read data returned by register file.
REQ-011 SHALL have port out_valid  output  1  out_addr/out_data valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts current word.
REQ-013 SHALL have port out_addr  output  5  register index of presented word.
REQ-014 SHALL have port out_data  output  32  captured register value.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse on scan completion (not on abort).

Function
REQ-017 SHALL implement states IDLE, ISSUE, SETTLE, CAPTURE, PRESENT, DWELL.
REQ-018 IDLE: start=1 -> ISSUE with index = FIRST_REG; else stay.
REQ-019 ISSUE: rd_addr = index; -> SETTLE next cycle.
REQ-020 SETTLE: rd_addr held; one cycle, covering the register file's falling-edge read update; -> CAPTURE.
REQ-021 CAPTURE: latch out_data <= rd_data, out_addr <= index; -> PRESENT.
REQ-022 rd_addr SHALL remain equal to index from ISSUE through CAPTURE; value in other states is don't-care but SHALL be stable (hold last).
REQ-023 PRESENT: out_valid=1; out_addr/out_data SHALL NOT change while out_valid=1 and out_ready=0.
REQ-024 PRESENT with out_ready=1: transfer completes that cycle; out_valid deasserts next cycle; -> DWELL.
REQ-025 DWELL: wait for step_tick=1; step_tick during any other state SHALL be ignored (no counting, no memory).
REQ-026 DWELL with step_tick and index < LAST_REG: index+1, -> ISSUE.
REQ-027 DWELL with step_tick and index == LAST_REG: AUTO_REPEAT=0 -> IDLE and done=1 for one cycle; AUTO_REPEAT=1 -> index = FIRST_REG, -> ISSUE, done pulses once per pass.
REQ-028 index SHALL never exceed LAST_REG; no 5-bit wrap past 31.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE next cycle, out_valid=0, no done; abort takes priority over out_ready and step_tick in the same cycle.
REQ-030 start while busy SHALL be ignored; start and abort simultaneous in IDLE: stay IDLE.
REQ-031 Minimum per-register latency: start-to-first out_valid = 4 cycles (ISSUE, SETTLE, CAPTURE, then PRESENT).
REQ-032 Concurrent writes to the register file during a scan SHALL be reflected only as returned by rd_data at CAPTURE; no hazard handling in this block.

Reset
REQ-033 Reset=1 SHALL asynchronously force state IDLE, index=FIRST_REG, rd_addr=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0.
REQ-034 Reset asserted mid-scan SHALL discard the scan; after release block waits for a new start.
REQ-035 First state change after release SHALL occur on a rising CLK edge only.

Verification
REQ-036 Defaults, regs x1=0x11, x2=0x22 preloaded, out_ready=1, step_tick every 8 cycles, start pulse -> 32 words out in order addr 0..31, x0 data 0, addr1 data 0x11, single done pulse after addr 31.
REQ-037 out_ready held 0 for 10 cycles at addr 5 -> out_valid, out_addr=5, out_data constant all 10 cycles; single transfer when ready rises.
REQ-038 FIRST_REG=3, LAST_REG=5, AUTO_REPEAT=1 -> sequence 3,4,5,3,4,5...; done pulses after each 5; index never 6.
REQ-039 abort asserted in PRESENT at addr 7 with out_ready=1 same cycle -> IDLE next cycle, no done, busy=0.
REQ-040 Reset asserted during SETTLE at addr 12, released, then start -> outputs zero during reset, scan restarts at FIRST_REG.
REQ-041 start pulse while busy and step_tick while PRESENT -> no restart, no skipped or double-advanced index.

Source files
------------

// File: rtl/reg_scan_reader.sv
// Sequential register-file scanner: reads each index from FIRST_REG to LAST_REG and
// presents it on a valid/ready port. It then waits for a dwell tick before moving on.
module reg_scan_reader #(
  parameter int FIRST_REG   = 0,
  parameter int LAST_REG    = 31,
  parameter int AUTO_REPEAT = 0
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        start,
  input  logic        abort,
  input  logic        step_tick,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_addr,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    PRESENT = 3'd4,
    DWELL   = 3'd5
  } state_t;

  state_t      state_reg, state_next;
  logic [4:0]  index_reg, index_next;
  logic [4:0]  rd_addr_reg;
  logic [4:0]  out_addr_reg;
  logic [31:0] out_data_reg;
  logic        done_reg, done_next;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_reg    <= IDLE;
      index_reg    <= FIRST_IDX;
      rd_addr_reg  <= 5'd0;
      out_addr_reg <= 5'd0;
      out_data_reg <= 32'd0;
      done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      done_reg  <= done_next;
      // The read address is loaded on entry to ISSUE and held until the next issue.
      if (state_next == ISSUE) begin
        rd_addr_reg <= index_next;
      end
      if (state_reg == CAPTURE && !abort) begin
        out_data_reg <= rd_data;
        out_addr_reg <= index_reg;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    done_next  = 1'b0;
    if (state_reg != IDLE && abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && !abort) begin
            state_next = ISSUE;
            index_next = FIRST_IDX;
          end
        end
        ISSUE:   state_next = SETTLE;
        SETTLE:  state_next = CAPTURE;
        CAPTURE: state_next = PRESENT;
        PRESENT: begin
          if (out_ready) begin
            state_next = DWELL;
          end
        end
        DWELL: begin
          if (step_tick) begin
            if (index_reg == LAST_IDX) begin
              done_next  = 1'b1;
              index_next = FIRST_IDX;
              state_next = (AUTO_REPEAT != 0) ? ISSUE : IDLE;
            end else begin
              index_next = index_reg + 5'd1;
              state_next = ISSUE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_reg != IDLE);
    out_valid = (state_reg == PRESENT);
    rd_addr   = rd_addr_reg;
    out_addr  = out_addr_reg;
    out_data  = out_data_reg;
    done      = done_reg;
  end

endmodule

// File: tb/tb_reg_scan_reader.sv
// Scoreboard bench for reg_scan_reader: a default full-range instance plus a 3..5
// auto-repeat instance. Both are fed by a falling-edge register-file model.
module tb_reg_scan_reader;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic Reset;

  logic        d_start, d_abort, d_step, d_out_ready, d_out_valid, d_busy, d_done;
  logic [4:0]  d_rd_addr, d_out_addr;
  logic [31:0] d_rd_data, d_out_data;

  logic        r_start, r_abort, r_step, r_out_ready, r_out_valid, r_busy, r_done;
  logic [4:0]  r_rd_addr, r_out_addr;
  logic [31:0] r_rd_data, r_out_data;

  reg_scan_reader u_def (
    .CLK(CLK), .Reset(Reset), .start(d_start), .abort(d_abort), .step_tick(d_step),
    .rd_addr(d_rd_addr), .rd_data(d_rd_data), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .out_addr(d_out_addr), .out_data(d_out_data),
    .busy(d_busy), .done(d_done)
  );

  reg_scan_reader #(.FIRST_REG(3), .LAST_REG(5), .AUTO_REPEAT(1)) u_rep (
    .CLK(CLK), .Reset(Reset), .start(r_start), .abort(r_abort), .step_tick(r_step),
    .rd_addr(r_rd_addr), .rd_data(r_rd_data), .out_valid(r_out_valid),
    .out_ready(r_out_ready), .out_addr(r_out_addr), .out_data(r_out_data),
    .busy(r_busy), .done(r_done)
  );

  // Register file: x0 reads zero, xN holds N*0x11, read port updates on the falling edge.
  logic [31:0] regs [32];
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h11;
    d_rd_data = 32'd0;
    r_rd_data = 32'd0;
  end
  always @(negedge CLK) begin
    d_rd_data <= regs[d_rd_addr];
    r_rd_data <= regs[r_rd_addr];
  end

  // Dwell tick for the default instance: every 8 cycles, plus a forced tick.
  logic [2:0] tick_cnt = 3'd0;
  logic       tick_en, d_step_force;
  always @(posedge CLK) tick_cnt <= tick_cnt + 3'd1;
  assign d_step = (tick_en && tick_cnt == 3'd0) || d_step_force;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [36:0] d_exp_q [$];
  logic [36:0] r_exp_q [$];

  int         d_xfer = 0, d_done_cnt = 0, r_xfer = 0, r_done_cnt = 0;
  logic [4:0] d_last_addr = 5'd0, r_last_addr = 5'd0;
  logic       d_done_prev = 1'b0, r_done_prev = 1'b0;

  always @(negedge CLK) begin
    logic [36:0] e;
    if (!Reset) begin
      if (d_out_valid && d_out_ready && !d_abort) begin
        if (d_exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL d_unexpected_word: got addr %0d, expected no transfer", d_out_addr);
        end else begin
          e = d_exp_q.pop_front();
          check("d_addr", 32'(d_out_addr), 32'(e[36:32]));
          check("d_data", d_out_data, e[31:0]);
        end
        $display("[TB] def word addr=%0d data=0x%0h", d_out_addr, d_out_data);
        d_last_addr = d_out_addr;
        d_xfer++;
      end
      if (d_done) begin
        d_done_cnt++;
        check("d_done_after_last", 32'(d_last_addr), 32'd31);
        check("d_done_width", 32'(d_done_prev), 32'd0);
      end
      d_done_prev = d_done;

      if (r_out_valid && r_out_ready && !r_abort) begin
        if (r_exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL r_unexpected_word: got addr %0d, expected no transfer", r_out_addr);
        end else begin
          e = r_exp_q.pop_front();
          check("r_addr", 32'(r_out_addr), 32'(e[36:32]));
          check("r_data", r_out_data, e[31:0]);
        end
        $display("[TB] rep word addr=%0d data=0x%0h", r_out_addr, r_out_data);
        r_last_addr = r_out_addr;
        r_xfer++;
      end
      if (r_busy) check("r_rd_addr_range", 32'(r_rd_addr >= 5'd3 && r_rd_addr <= 5'd5), 32'd1);
      if (r_done) begin
        r_done_cnt++;
        check("r_done_after_last", 32'(r_last_addr), 32'd5);
        check("r_done_width", 32'(r_done_prev), 32'd0);
      end
      r_done_prev = r_done;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    Reset = 1'b1;
    d_start = 0; d_abort = 0; d_out_ready = 0; tick_en = 0; d_step_force = 0;
    r_start = 0; r_abort = 0; r_out_ready = 0; r_step = 0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", 32'(d_busy), 0);
    check("rst_valid", 32'(d_out_valid), 0);
    check("rst_done", 32'(d_done), 0);
    check("rst_rd_addr", 32'(d_rd_addr), 0);
    check("rst_out_addr", 32'(d_out_addr), 0);
    check("rst_out_data", d_out_data, 0);
    check("rst_rep_busy", 32'(r_busy), 0);
    Reset = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("idle_no_start", 32'(d_busy), 0);

    // Full default scan with a stray start pulse in the middle.
    for (int a = 0; a < 32; a++) d_exp_q.push_back({5'(a), 32'(a) * 32'h11});
    d_out_ready = 1; tick_en = 1;
    d_start = 1;
    lat = 0;
    do begin
      @(posedge CLK); #1;
      d_start = 0;
      lat++;
    end while (!d_out_valid && lat < 20);
    check("start_latency", 32'(lat), 32'd4);
    check("first_data_x0", d_out_data, 32'h0);
    for (int k = 0; k < 2000 && d_xfer < 10; k++) begin @(posedge CLK); #1; end
    d_start = 1;
    @(posedge CLK); #1;
    d_start = 0;
    for (int k = 0; k < 3000 && d_done_cnt < 1; k++) begin @(posedge CLK); #1; end
    repeat (20) @(posedge CLK);
    #1;
    check("scan1_done_cnt", 32'(d_done_cnt), 32'd1);
    check("scan1_xfer", 32'(d_xfer), 32'd32);
    check("scan1_queue_empty", 32'(d_exp_q.size()), 0);
    check("scan1_idle", 32'(d_busy), 0);

    // Stall at addr 5, ignored start/tick while presenting, dwell waits, abort at addr 7.
    d_out_ready = 0;
    for (int a = 0; a < 7; a++) d_exp_q.push_back({5'(a), 32'(a) * 32'h11});
    d_start = 1;
    @(posedge CLK); #1;
    d_start = 0;
    for (int a = 0; a < 8; a++) begin
      for (int k = 0; k < 100 && !d_out_valid; k++) begin @(posedge CLK); #1; end
      check("t2_valid", 32'(d_out_valid), 1);
      check("t2_addr", 32'(d_out_addr), 32'(a));
      if (a == 5) begin
        for (int c = 0; c < 10; c++) begin
          check("stall_valid", 32'(d_out_valid), 1);
          check("stall_addr", 32'(d_out_addr), 32'd5);
          check("stall_data", d_out_data, 32'h55);
          d_step_force = 1;
          d_start = (c % 3 == 0);
          @(posedge CLK); #1;
        end
        d_step_force = 0;
        d_start = 0;
      end
      if (a == 7) begin
        d_abort = 1; d_out_ready = 1;
        @(posedge CLK); #1;
        d_abort = 0; d_out_ready = 0;
        check("abort_valid", 32'(d_out_valid), 0);
        check("abort_busy", 32'(d_busy), 0);
        check("abort_done", 32'(d_done), 0);
      end else begin
        if (a == 5) tick_en = 0;
        d_out_ready = 1;
        @(posedge CLK); #1;
        d_out_ready = 0;
        check("t2_valid_drop", 32'(d_out_valid), 0);
        if (a == 5) begin
          repeat (10) @(posedge CLK);
          #1;
          check("dwell_hold_addr", 32'(d_rd_addr), 32'd5);
          check("dwell_busy", 32'(d_busy), 1);
          tick_en = 1;
        end
      end
    end
    repeat (20) @(posedge CLK);
    #1;
    check("abort_no_done", 32'(d_done_cnt), 32'd1);
    check("t2_queue_empty", 32'(d_exp_q.size()), 0);
    check("t2_idle", 32'(d_busy), 0);

    // Reset during SETTLE of addr 12, then restart from FIRST_REG.
    for (int a = 0; a < 12; a++) d_exp_q.push_back({5'(a), 32'(a) * 32'h11});
    d_out_ready = 1;
    d_start = 1;
    @(posedge CLK); #1;
    d_start = 0;
    for (int k = 0; k < 2000 && !(d_busy && d_rd_addr == 5'd12); k++) begin @(posedge CLK); #1; end
    @(posedge CLK);
    #3;
    Reset = 1'b1;
    #1;
    check("arst_rd_addr", 32'(d_rd_addr), 0);
    check("arst_valid", 32'(d_out_valid), 0);
    check("arst_out_addr", 32'(d_out_addr), 0);
    check("arst_out_data", d_out_data, 0);
    check("arst_busy", 32'(d_busy), 0);
    check("arst_done", 32'(d_done), 0);
    repeat (2) @(posedge CLK);
    #3;
    Reset = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check("post_rst_idle", 32'(d_busy), 0);
    check("pre_rst_words", 32'(d_exp_q.size()), 0);
    for (int a = 0; a < 3; a++) d_exp_q.push_back({5'(a), 32'(a) * 32'h11});
    d_start = 1;
    @(posedge CLK); #1;
    d_start = 0;
    for (int k = 0; k < 1000 && d_exp_q.size() != 0; k++) begin @(posedge CLK); #1; end
    check("restart_words", 32'(d_exp_q.size()), 0);
    d_abort = 1;
    @(posedge CLK); #1;
    d_abort = 0;
    check("restart_abort_idle", 32'(d_busy), 0);

    // Auto-repeat instance over 3..5 for three passes.
    r_step = 1; r_out_ready = 1;
    for (int p = 0; p < 3; p++)
      for (int a = 3; a <= 5; a++) r_exp_q.push_back({5'(a), 32'(a) * 32'h11});
    r_start = 1;
    @(posedge CLK); #1;
    r_start = 0;
    for (int k = 0; k < 500 && r_done_cnt < 3; k++) begin @(posedge CLK); #1; end
    r_abort = 1;
    @(posedge CLK); #1;
    r_abort = 0;
    repeat (10) @(posedge CLK);
    #1;
    check("rep_done_cnt", 32'(r_done_cnt), 32'd3);
    check("rep_xfer", 32'(r_xfer), 32'd9);
    check("rep_queue_empty", 32'(r_exp_q.size()), 0);
    check("rep_idle", 32'(r_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
